// File: rtl/fpu_issue_if.sv
// Issue-stage bundle: decoder request, shared FP unit protocol and writeback handshake.
interface fpu_issue_if #(
    parameter int unsigned RD_W = 5
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [31:0]     req_a;
    logic [31:0]     req_b;
    logic [RD_W-1:0] req_rd;

    logic [31:0]     unit_adata;
    logic [31:0]     unit_bdata;
    logic [3:0]      unit_en;
    logic [3:0]      unit_done;
    logic [127:0]    unit_result;

    logic            wb_valid;
    logic            wb_ready;
    logic [31:0]     wb_data;
    logic [RD_W-1:0] wb_rd;
    logic            wb_err;

    logic            busy;

    // Environment side: decoder, arithmetic units and writeback.
    modport master (
        output req_valid, req_op, req_a, req_b, req_rd,
        output unit_done, unit_result,
        output wb_ready,
        input  req_ready, unit_adata, unit_bdata, unit_en,
        input  wb_valid, wb_data, wb_rd, wb_err, busy
    );

    // Issue stage side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_rd,
        input  unit_done, unit_result,
        input  wb_ready,
        output req_ready, unit_adata, unit_bdata, unit_en,
        output wb_valid, wb_data, wb_rd, wb_err, busy
    );
endinterface

// File: rtl/fpu_issue.sv
// Single-outstanding FP issue/collect stage: launches one unit op (or computes a
// sign-only op locally), waits for done with a timeout, and hands the result to writeback.
module fpu_issue #(
    parameter int unsigned RD_W    = 5,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic     clk,
    input  logic     rstn,
    fpu_issue_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_t;

    state_t          r_state;
    logic [1:0]      r_sel;
    logic [RD_W-1:0] r_rd;
    logic [31:0]     r_adata;
    logic [31:0]     r_bdata;
    logic [3:0]      r_en;
    logic            r_wb_valid;
    logic [31:0]     r_wb_data;
    logic            r_wb_err;
    logic [CNT_W-1:0] r_cnt;

    logic [6:0]      w_res_lsb;
    logic            w_sel_done;
    logic [31:0]     w_sel_result;
    logic            w_timeout;

    assign w_res_lsb    = {r_sel, 5'b00000};
    assign w_sel_done   = bus.unit_done[r_sel];
    assign w_sel_result = bus.unit_result[w_res_lsb +: 32];
    // Fires on the edge that would complete the TIMEOUT-th WAIT cycle.
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_rd       <= '0;
            r_adata    <= '0;
            r_bdata    <= '0;
            r_en       <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_err   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_sel   <= bus.req_op[1:0];
                        r_rd    <= bus.req_rd;
                        r_adata <= bus.req_a;
                        r_bdata <= bus.req_b;
                        if (!bus.req_op[2]) begin
                            r_en    <= 4'b0001 << bus.req_op[1:0];
                            r_state <= S_ISSUE;
                        end else begin
                            r_wb_valid <= 1'b1;
                            r_wb_err   <= 1'b0;
                            r_state    <= S_WB;
                            case (bus.req_op[1:0])
                                2'b00:   r_wb_data <= {~bus.req_a[31], bus.req_a[30:0]};
                                2'b01:   r_wb_data <= {1'b0, bus.req_a[30:0]};
                                2'b10:   r_wb_data <= bus.req_a;
                                default: begin
                                    r_wb_data <= '0;
                                    r_wb_err  <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                // en must be a single-cycle pulse or the unit would restart.
                S_ISSUE: begin
                    r_en    <= '0;
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_sel_done) begin
                        r_wb_data  <= w_sel_result;
                        r_wb_err   <= 1'b0;
                        r_wb_valid <= 1'b1;
                        r_state    <= S_WB;
                    end else if (w_timeout) begin
                        r_wb_data  <= '0;
                        r_wb_err   <= 1'b1;
                        r_wb_valid <= 1'b1;
                        r_state    <= S_WB;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    if (bus.wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.unit_adata = r_adata;
    assign bus.unit_bdata = r_bdata;
    assign bus.unit_en    = r_en;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_data    = r_wb_data;
    assign bus.wb_rd      = r_rd;
    assign bus.wb_err     = r_wb_err;
endmodule
